// File: rtl/cla_pipe_subtractor_pkg.sv
// Shared types and look-ahead helper for the pipelined CLA subtractor.
// Stage records are sized for the widest supported operand (CLA_MAX_W); narrower instances leave the upper bits at zero.
package cla_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int CLA_MAX_W = 64;

  typedef struct packed {
    logic                 vld;
    logic [CLA_MAX_W-1:0] diff;
    logic [CLA_MAX_W-1:0] rem_a;
    logic [CLA_MAX_W-1:0] rem_bn;
    logic                 carry;
  } stage_t;

  typedef struct packed {
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;
  } nib_t;

  // Generate/propagate and the full look-ahead carry vector of one nibble.
  // c[i] is the carry into bit i; c[4] is the nibble carry-out.
  function automatic nib_t cla_nibble(input logic [NIBBLE_W-1:0] a,
                                      input logic [NIBBLE_W-1:0] b_n,
                                      input logic                cin);
    logic [NIBBLE_W-1:0] g;
    nib_t                r;
    g      = a & b_n;
    r.p    = a ^ b_n;
    r.c[0] = cin;
    r.c[1] = g[0] | (r.p[0] & cin);
    r.c[2] = g[1] | (r.p[1] & g[0]) | (r.p[1] & r.p[0] & cin);
    r.c[3] = g[2] | (r.p[2] & g[1]) | (r.p[2] & r.p[1] & g[0])
           | (r.p[2] & r.p[1] & r.p[0] & cin);
    r.c[4] = g[3] | (r.p[3] & g[2]) | (r.p[3] & r.p[2] & g[1])
           | (r.p[3] & r.p[2] & r.p[1] & g[0])
           | (r.p[3] & r.p[2] & r.p[1] & r.p[0] & cin);
    return r;
  endfunction

endpackage

// File: rtl/cla_pipe_subtractor_slice.sv
// cla4_slice: combinational 4-bit carry-look-ahead nibble computing a + b_n + cin.
// c3 is the carry into bit 3, needed by the top slice for signed overflow.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b_n,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout
);

  nib_t nib;

  assign nib  = cla_nibble(a, b_n, cin);
  assign s    = nib.p ^ nib.c[3:0];
  assign c3   = nib.c[3];
  assign cout = nib.c[4];

endmodule

// File: rtl/cla_pipe_subtractor.sv
// Pipelined a - b - bin as a + ~b + ~bin, one 4-bit CLA slice per stage, carry registered between stages.
// Single global enable stalls every stage on output backpressure. Define CLA_SUB_SATURATE_EN to clamp underflowing results to zero.
module cla_pipe_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / NIBBLE_W;

  stage_t           stg [STAGES];
  stage_t           nxt [STAGES];
  logic             en;
  logic [WIDTH-1:0] fin_diff;
  logic             fin_c3;
  logic             fin_cout;

  assign out_valid = stg[STAGES-1].vld;
  assign en        = ~(out_valid & ~out_ready);
  assign in_ready  = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t     src;
    logic [3:0] s;
    logic       cout;

    // Stage 0 consumes the raw operands; later stages consume the previous register.
    if (k == 0) begin : g_first
      assign src = '{vld:    in_valid,
                     diff:   '0,
                     rem_a:  CLA_MAX_W'(in_a),
                     rem_bn: CLA_MAX_W'(~in_b),
                     carry:  ~in_bin};
    end else begin : g_next
      assign src = stg[k-1];
    end

    if (k == STAGES-1) begin : g_last
      cla4_slice u_slice (
        .a    (src.rem_a[3:0]),
        .b_n  (src.rem_bn[3:0]),
        .cin  (src.carry),
        .s    (s),
        .c3   (fin_c3),
        .cout (cout)
      );
      assign fin_cout = cout;
      assign fin_diff = nxt[k].diff[WIDTH-1:0];
    end else begin : g_mid
      logic c3_unused;
      cla4_slice u_slice (
        .a    (src.rem_a[3:0]),
        .b_n  (src.rem_bn[3:0]),
        .cin  (src.carry),
        .s    (s),
        .c3   (c3_unused),
        .cout (cout)
      );
    end

    assign nxt[k] = '{vld:    src.vld,
                      diff:   src.diff | (CLA_MAX_W'(s) << (NIBBLE_W * k)),
                      rem_a:  src.rem_a >> NIBBLE_W,
                      rem_bn: src.rem_bn >> NIBBLE_W,
                      carry:  cout};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stg[k] <= '0;
      end
      out_diff   <= '0;
      out_borrow <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        stg[k] <= nxt[k];
      end
`ifdef CLA_SUB_SATURATE_EN
      out_diff   <= fin_cout ? fin_diff : '0;
`else
      out_diff   <= fin_diff;
`endif
      out_borrow <= ~fin_cout;
      out_ovf    <= fin_c3 ^ fin_cout;
    end
  end

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// Scoreboard bench for cla_pipe_subtractor at WIDTH=16: directed vectors, backpressure hold, mid-stream reset.
// Expected responses are queued on acceptance and checked by an independent output monitor.
module tb_cla_pipe_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_bin;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_diff;
  logic        out_borrow;
  logic        out_ovf;

  cla_pipe_subtractor #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_bin     (in_bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        br;
    logic        ov;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          hold_cycles = 0;
  int          hold_left = 0;
  bit          arm_hold = 1'b0;
  logic [17:0] exp_q [$];

  function automatic logic [17:0] mk(input logic [15:0] d, input logic br, input logic ov);
`ifdef CLA_SUB_SATURATE_EN
    if (br) d = 16'h0000;
`endif
    return {d, br, ov};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic send(input vec_t v);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_bin   = v.bin;
    #1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      chk("send_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(mk(v.d, v.br, v.ov));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_lat(input string name);
    repeat (2) @(posedge clk);
    #1 chk({name, "_early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 chk({name, "_on_time"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    chk({name, "_drain"}, exp_q.size(), 32'd0);
  endtask

  // Downstream model: hold out_ready low for 3 cycles once armed and a result appears.
  initial begin
    forever begin
      @(negedge clk);
      if (arm_hold && out_valid) begin
        arm_hold  = 1'b0;
        hold_left = 3;
      end
      out_ready = (hold_left == 0);
      if (hold_left > 0) hold_left--;
    end
  end

  // Output monitor.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid) begin
        if (out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result got diff=%h borrow=%b ovf=%b required none",
                     out_diff, out_borrow, out_ovf);
          end else begin
            e = exp_q.pop_front();
            if ({out_diff, out_borrow, out_ovf} !== e) begin
              fails++;
              $display("FAIL result got diff=%h borrow=%b ovf=%b required diff=%h borrow=%b ovf=%b",
                       out_diff, out_borrow, out_ovf, e[17:2], e[1], e[0]);
            end
          end
        end else begin
          hold_cycles++;
          chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
          if (exp_q.size() != 0) chk("hold_diff_stable", {16'd0, out_diff}, {16'd0, exp_q[0][17:2]});
          else chk("hold_queue", exp_q.size(), 32'd1);
        end
      end
    end
  end

  vec_t first_v;
  vec_t dir [8];
  vec_t bp  [8];
  vec_t rv  [3];
  vec_t post_v;

  initial begin
    first_v = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    dir = '{
      '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0},
      '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0},
      '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1},
      '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1},
      '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0},
      '{16'h0010, 16'h0020, 1'b0, 16'hFFF0, 1'b1, 1'b0},
      '{16'h0020, 16'h0010, 1'b0, 16'h0010, 1'b0, 1'b0}
    };
    bp = '{
      '{16'hA000, 16'h0001, 1'b0, 16'h9FFF, 1'b0, 1'b0},
      '{16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1, 1'b1},
      '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0},
      '{16'h1000, 16'h1000, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{16'h0F0F, 16'h00F0, 1'b0, 16'h0E1F, 1'b0, 1'b0},
      '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0000, 1'b1, 16'h7FFE, 1'b0, 1'b0},
      '{16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0}
    };
    rv = '{
      '{16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0},
      '{16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0},
      '{16'h3333, 16'h0003, 1'b0, 16'h3330, 1'b0, 1'b0}
    };
    post_v = '{16'h4321, 16'h1234, 1'b0, 16'h30ED, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_out_diff",   {16'd0, out_diff},   32'd0);
    chk("rst_out_borrow", {31'd0, out_borrow}, 32'd0);
    chk("rst_out_ovf",    {31'd0, out_ovf},    32'd0);

    send(first_v);
    check_lat("first");
    drain("first");

    foreach (dir[i]) send(dir[i]);
    drain("directed");

    arm_hold = 1'b1;
    foreach (bp[i]) send(bp[i]);
    drain("backpressure");
    chk("hold_cycles", hold_cycles, 32'd3);

    foreach (rv[i]) send(rv[i]);
    @(negedge clk) rst = 1'b1;
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    #1 chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    send(post_v);
    check_lat("post_rst");
    drain("post_rst");

    repeat (10) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
